// File: rtl/led_mode_ctrl.sv
// Four-key LED mode controller: OFF / STEADY / BLINK / RUN, with speed and
// run-direction toggles. The animation step timer is shared by all modes.
//
// state       | meaning
// ------------+-------------------------------------------------
// MODE_OFF    | all LEDs dark
// MODE_STEADY | all LEDs lit
// MODE_BLINK  | all LEDs follow phase, phase inverts every tick
// MODE_RUN    | single lit LED (pos) rotates every tick
module led_mode_ctrl #(
  parameter int unsigned TICK_SLOW = 25_000_000,
  parameter int unsigned TICK_FAST = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  output logic [3:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_RUN    = 2'd3
  } mode_e;

  localparam logic [24:0] LAST_SLOW = 25'(TICK_SLOW - 1);
  localparam logic [24:0] LAST_FAST = 25'(TICK_FAST - 1);
  localparam logic [3:0]  POS_LEFT_START  = 4'b0001;
  localparam logic [3:0]  POS_RIGHT_START = 4'b1000;

  mode_e       mode_q, mode_d;
  logic        fast_q, fast_d;
  logic        dir_right_q, dir_right_d;
  logic [3:0]  pos_q, pos_d;
  logic        phase_q, phase_d;
  logic [24:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  key_prev_q, key_prev_d;
  logic [3:0]  led_q, led_d;

  logic        key_valid;
  logic        key_evt;
  logic [24:0] tick_last;
  logic        tick;

  always_comb begin
    key_valid = (key_code != 4'd0) && (key_code <= 4'd4);
    key_evt   = key_valid && (key_prev_q == 4'd0);
    tick_last = fast_q ? LAST_FAST : LAST_SLOW;
    // >= keeps the timer bounded even if the limit ever dropped below the count
    tick      = (tick_cnt_q >= tick_last);
  end

  always_comb begin
    mode_d      = mode_q;
    fast_d      = fast_q;
    dir_right_d = dir_right_q;
    pos_d       = pos_q;
    phase_d     = phase_q;
    tick_cnt_d  = tick_cnt_q + 25'd1;
    key_prev_d  = key_code;

    if (key_evt) begin
      // A key event always restarts the step and swallows a coincident tick
      tick_cnt_d = 25'd0;
      case (key_code)
        4'd1: begin
          case (mode_q)
            MODE_OFF:    mode_d = MODE_STEADY;
            MODE_STEADY: begin
              mode_d  = MODE_BLINK;
              phase_d = 1'b1;
            end
            MODE_BLINK: begin
              mode_d = MODE_RUN;
              pos_d  = dir_right_q ? POS_RIGHT_START : POS_LEFT_START;
            end
            default:     mode_d = MODE_OFF;
          endcase
        end
        4'd2: fast_d      = ~fast_q;
        4'd3: dir_right_d = ~dir_right_q;
        4'd4: begin
          mode_d      = MODE_OFF;
          fast_d      = 1'b0;
          dir_right_d = 1'b0;
          pos_d       = POS_LEFT_START;
          phase_d     = 1'b1;
        end
        default: ;
      endcase
    end else if (tick) begin
      tick_cnt_d = 25'd0;
      case (mode_q)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_RUN:   pos_d = dir_right_q ? {pos_q[0], pos_q[3:1]}
                                        : {pos_q[2:0], pos_q[3]};
        default: ;
      endcase
    end
  end

  always_comb begin
    case (mode_q)
      MODE_OFF:    led_d = 4'b0000;
      MODE_STEADY: led_d = 4'b1111;
      MODE_BLINK:  led_d = phase_q ? 4'b1111 : 4'b0000;
      default:     led_d = pos_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      fast_q      <= 1'b0;
      dir_right_q <= 1'b0;
      pos_q       <= POS_LEFT_START;
      phase_q     <= 1'b1;
      tick_cnt_q  <= 25'd0;
      key_prev_q  <= 4'd0;
      led_q       <= 4'b0000;
    end else begin
      mode_q      <= mode_d;
      fast_q      <= fast_d;
      dir_right_q <= dir_right_d;
      pos_q       <= pos_d;
      phase_q     <= phase_d;
      tick_cnt_q  <= tick_cnt_d;
      key_prev_q  <= key_prev_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

endmodule
